// File: rtl/wb_mem_arbiter.sv
// Two-port Wishbone arbiter in front of a 64-bit byte-enable RAM with one-cycle read latency.
// Define WB_MEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module wb_mem_arbiter #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic [AW-3:0] i_wb0_adr,
    input  logic [31:0]   i_wb0_dat,
    input  logic [3:0]    i_wb0_sel,
    input  logic          i_wb0_we,
    input  logic          i_wb0_cyc,
    input  logic          i_wb0_stb,
    output logic [31:0]   o_wb0_rdt,
    output logic          o_wb0_ack,

    input  logic [AW-3:0] i_wb1_adr,
    input  logic [31:0]   i_wb1_dat,
    input  logic [3:0]    i_wb1_sel,
    input  logic          i_wb1_we,
    input  logic          i_wb1_cyc,
    input  logic          i_wb1_stb,
    output logic [31:0]   o_wb1_rdt,
    output logic          o_wb1_ack,

    output logic [AW-1:0] o_mem_addr,
    output logic [7:0]    o_mem_we,
    output logic [63:0]   o_mem_din,
    input  logic [63:0]   i_mem_dout
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          gnt;
    logic          gnt_nxt;
    logic          req0;
    logic          req1;
    logic          winner;

    logic [AW-3:0] adr_g;
    logic [31:0]   dat_g;
    logic [3:0]    sel_g;
    logic          we_g;
    logic          cyc_g;

    assign req0 = i_wb0_cyc & i_wb0_stb;
    assign req1 = i_wb1_cyc & i_wb1_stb;

    // The granted port drives the RAM in every state, so after reset port 0 is visible.
    assign adr_g = gnt ? i_wb1_adr : i_wb0_adr;
    assign dat_g = gnt ? i_wb1_dat : i_wb0_dat;
    assign sel_g = gnt ? i_wb1_sel : i_wb0_sel;
    assign we_g  = gnt ? i_wb1_we  : i_wb0_we;
    assign cyc_g = gnt ? i_wb1_cyc : i_wb0_cyc;

    assign o_mem_addr = {adr_g[AW-3:1], 3'b000};
    assign o_mem_din  = {dat_g, dat_g};

    // Word-address bit 0 picks the 32-bit half of the 64-bit RAM word.
    assign o_wb0_rdt = i_wb0_adr[0] ? i_mem_dout[63:32] : i_mem_dout[31:0];
    assign o_wb1_rdt = i_wb1_adr[0] ? i_mem_dout[63:32] : i_mem_dout[31:0];

`ifdef WB_MEM_ARB_FIXED_PRIO_EN
    assign winner = ~req0;
`else
    logic rr_ptr;
    logic rr_ptr_nxt;

    assign winner = (req0 & req1) ? rr_ptr : req1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else begin
            rr_ptr <= rr_ptr_nxt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
        end
    end

    // Ack decodes the ACK state; gating it with cyc lets a late abort suppress it.
    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        o_mem_we   = 8'h00;
        o_wb0_ack  = 1'b0;
        o_wb1_ack  = 1'b0;
`ifndef WB_MEM_ARB_FIXED_PRIO_EN
        rr_ptr_nxt = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    gnt_nxt   = winner;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (we_g) begin
                    o_mem_we = adr_g[0] ? {sel_g, 4'h0} : {4'h0, sel_g};
                end
                state_nxt = cyc_g ? ACK : IDLE;
            end
            ACK: begin
                state_nxt = IDLE;
                if (cyc_g) begin
                    o_wb0_ack  = ~gnt;
                    o_wb1_ack  = gnt;
`ifndef WB_MEM_ARB_FIXED_PRIO_EN
                    rr_ptr_nxt = ~gnt;
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: behavioural 64-bit RAM plus a scoreboard of expected acks.
module tb_wb_mem_arbiter;

    localparam int AW = 16;
    localparam int WA = AW - 2;
`ifdef WB_MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic [WA-1:0] wb0_adr = '0;
    logic [31:0]   wb0_dat = '0;
    logic [3:0]    wb0_sel = '0;
    logic          wb0_we = 1'b0;
    logic          wb0_cyc = 1'b0;
    logic          wb0_stb = 1'b0;
    logic [31:0]   wb0_rdt;
    logic          wb0_ack;

    logic [WA-1:0] wb1_adr = '0;
    logic [31:0]   wb1_dat = '0;
    logic [3:0]    wb1_sel = '0;
    logic          wb1_we = 1'b0;
    logic          wb1_cyc = 1'b0;
    logic          wb1_stb = 1'b0;
    logic [31:0]   wb1_rdt;
    logic          wb1_ack;

    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_we;
    logic [63:0]   mem_din;
    logic [63:0]   mem_dout = '0;

    logic [63:0]   mem [0:(1 << (AW - 3)) - 1];

    typedef struct {
        bit          port;
        logic [31:0] rdt;
        bit          chk;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    wb_mem_arbiter #(.AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wb0_adr  (wb0_adr),
        .i_wb0_dat  (wb0_dat),
        .i_wb0_sel  (wb0_sel),
        .i_wb0_we   (wb0_we),
        .i_wb0_cyc  (wb0_cyc),
        .i_wb0_stb  (wb0_stb),
        .o_wb0_rdt  (wb0_rdt),
        .o_wb0_ack  (wb0_ack),
        .i_wb1_adr  (wb1_adr),
        .i_wb1_dat  (wb1_dat),
        .i_wb1_sel  (wb1_sel),
        .i_wb1_we   (wb1_we),
        .i_wb1_cyc  (wb1_cyc),
        .i_wb1_stb  (wb1_stb),
        .o_wb1_rdt  (wb1_rdt),
        .o_wb1_ack  (wb1_ack),
        .o_mem_addr (mem_addr),
        .o_mem_we   (mem_we),
        .o_mem_din  (mem_din),
        .i_mem_dout (mem_dout)
    );

    // Byte-enable RAM with registered read (old data on a same-cycle write).
    always @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (mem_we[b]) mem[mem_addr[AW-1:3]][b*8 +: 8] <= mem_din[b*8 +: 8];
        end
        mem_dout <= mem[mem_addr[AW-1:3]];
    end

    function automatic logic [AW-1:0] exp_addr(input logic [WA-1:0] a);
        return {a[WA-1:1], 3'b000};
    endfunction

    function automatic logic [7:0] exp_we(input bit we, input logic [3:0] sel, input logic [WA-1:0] a);
        if (!we) return 8'h00;
        return a[0] ? {sel, 4'h0} : {4'h0, sel};
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input bit p, input bit req, input bit we, input logic [WA-1:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
        if (!p) begin
            wb0_cyc = req; wb0_stb = req; wb0_we = we; wb0_adr = adr; wb0_dat = dat; wb0_sel = sel;
        end else begin
            wb1_cyc = req; wb1_stb = req; wb1_we = we; wb1_adr = adr; wb1_dat = dat; wb1_sel = sel;
        end
    endtask

    task automatic push_exp(input bit p, input logic [31:0] rdt, input bit chk);
        exp_t e;
        e.port = p;
        e.rdt  = rdt;
        e.chk  = chk;
        sb.push_back(e);
    endtask

    // Pops the oldest expectation on every observed ack.
    task automatic score_ack(input string tag, input int lat, input int exp_lat);
        exp_t e;
        check_output("sb_nonempty", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_output("ack0", 64'(wb0_ack), 64'(!e.port));
            check_output("ack1", 64'(wb1_ack), 64'(e.port));
            if (e.chk) check_output("rdt", 64'(e.port ? wb1_rdt : wb0_rdt), 64'(e.rdt));
        end
        check_output(tag, 64'(lat), 64'(exp_lat));
    endtask

    // One uncontested transfer started from IDLE.
    task automatic apply_stimulus(input bit p, input bit we, input logic [WA-1:0] adr,
                                  input logic [31:0] dat, input logic [3:0] sel, input logic [31:0] rd_exp);
        bit got;
        push_exp(p, rd_exp, !we);
        @(posedge clk); #1;
        set_port(p, 1'b1, we, adr, dat, sel);
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check_output("mem_we", 64'(mem_we), 64'(exp_we(we, sel, adr)));
                check_output("mem_addr", 64'(mem_addr), 64'(exp_addr(adr)));
                check_output("mem_din", mem_din, {dat, dat});
            end
            if (wb0_ack | wb1_ack) begin
                score_ack("latency", k, 2);
                got = 1'b1;
                break;
            end
        end
        check_output("ack_seen", 64'(got), 64'(1));
        @(posedge clk); #1;
        set_port(p, 1'b0, we, adr, dat, sel);
        @(negedge clk);
        check_output("ack_single", 64'({wb0_ack, wb1_ack}), 64'(0));
    endtask

    // Both ports read continuously until n acks have been scored.
    task automatic run_contention(input int n, input logic [WA-1:0] adr0, input logic [WA-1:0] adr1);
        int seen;
        int last_k;
        seen   = 0;
        last_k = -1;
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b0, adr0, 32'h0, 4'hF);
        set_port(1'b1, 1'b1, 1'b0, adr1, 32'h0, 4'hF);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (wb0_ack | wb1_ack) begin
                score_ack("ack_spacing", k - last_k, 3);
                last_k = k;
                seen++;
                if (seen == n) break;
            end
        end
        check_output("ack_count", 64'(seen), 64'(n));
        @(posedge clk); #1;
        set_port(1'b0, 1'b0, 1'b0, adr0, 32'h0, 4'hF);
        set_port(1'b1, 1'b0, 1'b0, adr1, 32'h0, 4'hF);
        @(negedge clk);
    endtask

    initial begin
        $display("[TB] start, fixed priority = %0d", FIXED);

        // Reset state: RAM side follows port 0.
        set_port(1'b0, 1'b0, 1'b0, 14'h0F3, 32'h1234_5678, 4'h0);
        set_port(1'b1, 1'b0, 1'b0, 14'h3A1, 32'h0000_0009, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_ack", 64'({wb0_ack, wb1_ack}), 64'(0));
        check_output("rst_mem_we", 64'(mem_we), 64'(0));
        check_output("rst_mem_addr", 64'(mem_addr), 64'(exp_addr(14'h0F3)));
        check_output("rst_mem_din", mem_din, 64'h1234_5678_1234_5678);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Port 1 fills both halves of one RAM word, then reads them back.
        apply_stimulus(1'b1, 1'b1, 14'h004, 32'h3333_4444, 4'hF, 32'h0);
        apply_stimulus(1'b1, 1'b1, 14'h005, 32'h1111_2222, 4'hF, 32'h0);
        apply_stimulus(1'b1, 1'b0, 14'h004, 32'h0, 4'hF, 32'h3333_4444);
        apply_stimulus(1'b1, 1'b0, 14'h005, 32'h0, 4'hF, 32'h1111_2222);

        // Port 0 full write, partial upper-half write, read-back.
        apply_stimulus(1'b0, 1'b1, 14'h005, 32'hCAFE_F00D, 4'hF, 32'h0);
        apply_stimulus(1'b0, 1'b1, 14'h005, 32'hDEAD_BEEF, 4'b0011, 32'h0);
        apply_stimulus(1'b0, 1'b0, 14'h005, 32'h0, 4'hF, 32'hCAFE_BEEF);
        apply_stimulus(1'b1, 1'b0, 14'h004, 32'h0, 4'hF, 32'h3333_4444);

        // Abort: port 0 drops cyc while in ACK; no ack, write still lands.
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b1, 14'h00A, 32'hA5A5_A5A5, 4'hF);
        @(negedge clk);
        @(negedge clk);
        check_output("abort_mem_we", 64'(mem_we), 64'(8'h0F));
        check_output("abort_mem_addr", 64'(mem_addr), 64'(exp_addr(14'h00A)));
        @(posedge clk); #1;
        set_port(1'b0, 1'b0, 1'b1, 14'h00A, 32'hA5A5_A5A5, 4'hF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output("abort_no_ack", 64'({wb0_ack, wb1_ack}), 64'(0));
        end

        // Contention after abort: the pointer must still favour port 0.
        for (int i = 0; i < 2; i++) begin
            bit p;
            p = FIXED ? 1'b0 : 1'(i % 2);
            push_exp(p, p ? 32'h3333_4444 : 32'hA5A5_A5A5, 1'b1);
        end
        run_contention(2, 14'h00A, 14'h004);

        // Serve port 0 so the pointer moves to port 1, then reset in the middle of a write.
        apply_stimulus(1'b0, 1'b0, 14'h005, 32'h0, 4'hF, 32'hCAFE_BEEF);
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b1, 14'h00C, 32'h0BAD_F00D, 4'hF);
        @(negedge clk);
        @(negedge clk);
        check_output("rstmid_mem_we", 64'(mem_we), 64'(8'h0F));
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_output("rstmid_ack", 64'({wb0_ack, wb1_ack}), 64'(0));
            check_output("rstmid_mem_we0", 64'(mem_we), 64'(0));
        end
        @(posedge clk); #1;
        set_port(1'b0, 1'b0, 1'b0, 14'h00C, 32'h0, 4'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("rstmid_idle_ack", 64'({wb0_ack, wb1_ack}), 64'(0));

        // Continuous requests from reset: 0,1,0,1 (or port 0 only with fixed priority).
        for (int i = 0; i < 4; i++) begin
            bit p;
            p = FIXED ? 1'b0 : 1'(i % 2);
            push_exp(p, p ? 32'h3333_4444 : 32'hCAFE_BEEF, 1'b1);
        end
        run_contention(4, 14'h005, 14'h004);

        check_output("sb_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
